// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT machine-timer block.
//  - Register offsets (addr[15:0]) of the four 32-bit windows onto mtime/mtimecmp.
//  - AXI response codes used by the slave.
//  - Register decode and byte-lane merge helpers shared by the top and the mtime counter.
package clint_pkg;

    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } clint_reg_e;

    function automatic clint_reg_e clint_decode(input logic [15:0] offset);
        clint_reg_e sel;
        case (offset)
            CLINT_MTIMECMP_LO: sel = REG_CMP_LO;
            CLINT_MTIMECMP_HI: sel = REG_CMP_HI;
            CLINT_MTIME_LO:    sel = REG_TIME_LO;
            CLINT_MTIME_HI:    sel = REG_TIME_HI;
            default:           sel = REG_NONE;
        endcase
        return sel;
    endfunction

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// Free-running 64-bit mtime with a TICK_DIV prescaler and a byte-enabled load port.
// Ports:
//  clock, reset           clock and synchronous active-high reset
//  load_lo / load_hi      bus write to mtime[31:0] / mtime[63:32] this cycle
//  load_strb, load_data   byte enables and data for the load
//  mtime                  current (registered) mtime
//  mtime_next             value mtime takes at the next edge (used for the compare)
module clint_mtime_counter
    import clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [3:0]  load_strb,
    input  logic [31:0] load_data,
    output logic [63:0] mtime,
    output logic [63:0] mtime_next
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] prescaler_q, prescaler_d;
    logic [63:0]      mtime_q, mtime_d;
    logic             tick;
    logic             load;

    always_comb begin
        tick        = (prescaler_q == PRE_LAST);
        load        = (load_lo | load_hi) & (|load_strb);
        prescaler_d = tick ? '0 : prescaler_q + PRE_W'(1);
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        // A bus write suppresses this cycle's increment and restarts the prescaler,
        // so software sees exactly the value it wrote for a full tick period.
        if (load) begin
            prescaler_d = '0;
            mtime_d     = mtime_q;
            if (load_lo) begin
                mtime_d[31:0] = merge_bytes(mtime_q[31:0], load_data, load_strb);
            end
            if (load_hi) begin
                mtime_d[63:32] = merge_bytes(mtime_q[63:32], load_data, load_strb);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler_q <= '0;
            mtime_q     <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            mtime_q     <= mtime_d;
        end
    end

    assign mtime      = mtime_q;
    assign mtime_next = mtime_d;

endmodule

// File: rtl/clint_timer.sv
// CLINT machine timer: 64-bit mtime/mtimecmp behind an AXI4-Lite slave, driving mtip.
// Ports:
//  clock, reset             clock and synchronous active-high reset
//  mtip / mtip_clear        level interrupt to writeback / one-cycle acknowledge
//  ar*, r*                  AXI4-Lite read address / data channels (one outstanding read)
//  aw*, w*, b*              AXI4-Lite write address / data / response (one outstanding write)
// Only addr[15:0] is decoded; unmapped accesses answer SLVERR (reads return 0).
module clint_timer
    import clint_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int ADDR_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mtip,
    input  logic              mtip_clear,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp
);
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] shadow_q, shadow_d;
    logic        shadow_sel_q, shadow_sel_d;   // previous read was mtime[31:0]
    logic        aw_held_q, aw_held_d;
    logic [15:0] awaddr_q, awaddr_d;
    logic        w_held_q, w_held_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        armed_q, armed_d;
    logic        pending_q, pending_d;

    logic [63:0] mtime, mtime_next;
    logic        ar_fire, aw_fire, w_fire, commit, wr_en;
    clint_reg_e  rd_sel, wr_sel;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        load_lo, load_hi, cmp_write;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{araddr[ADDR_W-1:16], awaddr[ADDR_W-1:16]};

    assign arready = !rvalid_q;
    assign awready = !aw_held_q & !bvalid_q;
    assign wready  = !w_held_q & !bvalid_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign mtip    = pending_q;

    // Write commit: each channel is either already latched or arriving this cycle.
    always_comb begin
        ar_fire   = arvalid & arready;
        aw_fire   = awvalid & awready;
        w_fire    = wvalid & wready;
        wr_addr   = aw_held_q ? awaddr_q : awaddr[15:0];
        wr_data   = w_held_q ? wdata_q : wdata;
        wr_strb   = w_held_q ? wstrb_q : wstrb;
        rd_sel    = clint_decode(araddr[15:0]);
        wr_sel    = clint_decode(wr_addr);
        commit    = (aw_held_q | aw_fire) & (w_held_q | w_fire);
        wr_en     = commit & (|wr_strb);
        load_lo   = wr_en & (wr_sel == REG_TIME_LO);
        load_hi   = wr_en & (wr_sel == REG_TIME_HI);
        cmp_write = wr_en & ((wr_sel == REG_CMP_LO) | (wr_sel == REG_CMP_HI));
    end

    clint_mtime_counter #(.TICK_DIV(TICK_DIV)) u_counter (
        .clock      (clock),
        .reset      (reset),
        .load_lo    (load_lo),
        .load_hi    (load_hi),
        .load_strb  (wr_strb),
        .load_data  (wr_data),
        .mtime      (mtime),
        .mtime_next (mtime_next)
    );

    always_comb begin
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        shadow_d     = shadow_q;
        shadow_sel_d = shadow_sel_q;
        aw_held_d    = aw_held_q;
        awaddr_d     = awaddr_q;
        w_held_d     = w_held_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        mtimecmp_d   = mtimecmp_q;
        armed_d      = armed_q;
        pending_d    = pending_q;

        // Read channel: registered values are used, so a same-cycle write is not visible.
        if (rvalid_q & rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_fire) begin
            rvalid_d     = 1'b1;
            rresp_d      = AXI_RESP_OKAY;
            shadow_sel_d = 1'b0;
            case (rd_sel)
                REG_CMP_LO:  rdata_d = mtimecmp_q[31:0];
                REG_CMP_HI:  rdata_d = mtimecmp_q[63:32];
                REG_TIME_LO: begin
                    // Snapshot the upper half so a following hi read is coherent.
                    rdata_d      = mtime[31:0];
                    shadow_d     = mtime[63:32];
                    shadow_sel_d = 1'b1;
                end
                REG_TIME_HI: rdata_d = shadow_sel_q ? shadow_q : mtime[63:32];
                default: begin
                    rdata_d = '0;
                    rresp_d = AXI_RESP_SLVERR;
                end
            endcase
        end

        // Write channels.
        if (bvalid_q & bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (wr_sel == REG_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end else begin
            if (aw_fire) begin
                aw_held_d = 1'b1;
                awaddr_d  = awaddr[15:0];
            end
            if (w_fire) begin
                w_held_d = 1'b1;
                wdata_d  = wdata;
                wstrb_d  = wstrb;
            end
        end
        if (wr_en & (wr_sel == REG_CMP_LO)) begin
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wr_data, wr_strb);
        end
        if (wr_en & (wr_sel == REG_CMP_HI)) begin
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wr_data, wr_strb);
        end

        // Interrupt: compare against the value mtime is about to take, so mtip
        // becomes visible in the same cycle mtime reaches mtimecmp.
        if (mtip_clear) begin
            pending_d = 1'b0;
        end
        if (armed_q && (mtime_next >= mtimecmp_q)) begin
            pending_d = 1'b1;
            armed_d   = 1'b0;
        end
        if (cmp_write) begin
            armed_d   = 1'b1;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= AXI_RESP_OKAY;
            shadow_q     <= '0;
            shadow_sel_q <= 1'b0;
            aw_held_q    <= 1'b0;
            awaddr_q     <= '0;
            w_held_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= AXI_RESP_OKAY;
            mtimecmp_q   <= '1;
            armed_q      <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            shadow_q     <= shadow_d;
            shadow_sel_q <= shadow_sel_d;
            aw_held_q    <= aw_held_d;
            awaddr_q     <= awaddr_d;
            w_held_q     <= w_held_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            mtimecmp_q   <= mtimecmp_d;
            armed_q      <= armed_d;
            pending_q    <= pending_d;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: directed scenarios plus a randomized AXI/mtip_clear phase,
// all checked every cycle against a transaction-level reference model.
module tb_clint_timer;
    localparam int TICK_DIV = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mtip;
    logic        mtip_clear = 1'b0;
    logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0;
    logic [31:0] araddr = '0, rdata;
    logic [1:0]  rresp, bresp;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;

    always #5 clock = ~clock;

    clint_timer #(.TICK_DIV(TICK_DIV), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset), .mtip(mtip), .mtip_clear(mtip_clear),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_mtime, m_cmp;
    int          m_pre;
    logic        m_armed, m_pending, m_rvalid, m_bvalid, m_aw_held, m_w_held, m_last_lo;
    logic [31:0] m_rdata, m_shadow, m_wdata;
    logic [1:0]  m_rresp, m_bresp;
    logic [15:0] m_awaddr;
    logic [3:0]  m_wstrb;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic        ar_acc, aw_acc, w_acc, commit, cmp_wr, mapped;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [63:0] t_next, n_cmp;
        int          p_next;
        logic        n_pending, n_armed;
        if (reset) begin
            m_mtime = '0; m_cmp = '1; m_pre = 0; m_armed = 0; m_pending = 0;
            m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_bvalid = 0; m_bresp = '0;
            m_aw_held = 0; m_w_held = 0; m_last_lo = 0; m_shadow = '0;
            m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
            return;
        end
        ar_acc = arvalid && !m_rvalid;
        aw_acc = awvalid && !m_aw_held && !m_bvalid;
        w_acc  = wvalid && !m_w_held && !m_bvalid;

        p_next = m_pre + 1;
        t_next = m_mtime;
        if (p_next == TICK_DIV) begin
            p_next = 0;
            t_next = m_mtime + 64'd1;
        end

        a = m_aw_held ? m_awaddr : awaddr[15:0];
        d = m_w_held ? m_wdata : wdata;
        s = m_w_held ? m_wstrb : wstrb;
        commit = (m_aw_held || aw_acc) && (m_w_held || w_acc);
        mapped = (a == 16'h4000) || (a == 16'h4004) || (a == 16'hBFF8) || (a == 16'hBFFC);
        cmp_wr = 0;
        n_cmp  = m_cmp;
        if (commit && s != 4'd0) begin
            case (a)
                16'h4000: begin n_cmp[31:0]  = lane_merge(m_cmp[31:0], d, s);  cmp_wr = 1; end
                16'h4004: begin n_cmp[63:32] = lane_merge(m_cmp[63:32], d, s); cmp_wr = 1; end
                16'hBFF8: begin t_next = m_mtime; t_next[31:0]  = lane_merge(m_mtime[31:0], d, s);  p_next = 0; end
                16'hBFFC: begin t_next = m_mtime; t_next[63:32] = lane_merge(m_mtime[63:32], d, s); p_next = 0; end
                default: ;
            endcase
        end

        // Read sees state before this edge.
        if (m_rvalid && rready) m_rvalid = 0;
        if (ar_acc) begin
            m_rvalid = 1;
            m_rresp  = 2'b00;
            case (araddr[15:0])
                16'h4000: m_rdata = m_cmp[31:0];
                16'h4004: m_rdata = m_cmp[63:32];
                16'hBFF8: m_rdata = m_mtime[31:0];
                16'hBFFC: m_rdata = m_last_lo ? m_shadow : m_mtime[63:32];
                default: begin m_rdata = '0; m_rresp = 2'b10; end
            endcase
            if (araddr[15:0] == 16'hBFF8) m_shadow = m_mtime[63:32];
            m_last_lo = (araddr[15:0] == 16'hBFF8);
        end

        n_pending = m_pending;
        n_armed   = m_armed;
        if (mtip_clear) n_pending = 0;
        if (m_armed && t_next >= m_cmp) begin n_pending = 1; n_armed = 0; end
        if (cmp_wr) begin n_armed = 1; n_pending = 0; end

        if (m_bvalid && bready) m_bvalid = 0;
        if (commit) begin
            m_bvalid = 1;
            m_bresp = mapped ? 2'b00 : 2'b10;
            m_aw_held = 0;
            m_w_held = 0;
        end else begin
            if (aw_acc) begin m_aw_held = 1; m_awaddr = awaddr[15:0]; end
            if (w_acc) begin m_w_held = 1; m_wdata = wdata; m_wstrb = wstrb; end
        end
        m_mtime = t_next; m_pre = p_next; m_cmp = n_cmp;
        m_pending = n_pending; m_armed = n_armed;
    endtask

    task automatic tick();
        logic        r_hs, b_hs;
        logic [31:0] r_d;
        logic [1:0]  r_r, b_r;
        r_hs = !reset && m_rvalid && rready;
        b_hs = !reset && m_bvalid && bready;
        r_d = m_rdata; r_r = m_rresp; b_r = m_bresp;
        model_step();
        @(posedge clock);
        #1;
        cyc++;
        if (r_hs) $display("[%0d] R  rdata=%08h rresp=%0d", cyc, r_d, r_r);
        if (b_hs) $display("[%0d] B  bresp=%0d", cyc, b_r);
        check("mtip", mtip, m_pending);
        check("rvalid", rvalid, m_rvalid);
        check("arready", arready, !m_rvalid);
        check("awready", awready, !m_aw_held && !m_bvalid);
        check("wready", wready, !m_w_held && !m_bvalid);
        check("bvalid", bvalid, m_bvalid);
        check("rdata", rdata, m_rdata);
        check("rresp", rresp, m_rresp);
        check("bresp", bresp, m_bresp);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int  guard;
        logic acc;
        arvalid = 1; araddr = addr; rready = 0;
        guard = 0;
        do begin
            acc = !m_rvalid;
            tick();
            guard++;
        end while (!acc && guard < 50);
        if (!acc) check("read_timeout", 1'b1, 1'b0);
        arvalid = 0;
        data = rdata; resp = rresp;
        rready = 1;
        tick();
        rready = 0;
    endtask

    task automatic wait_b_idle();
        int guard;
        guard = 0;
        bready = 1;
        while (m_bvalid && guard < 50) begin tick(); guard++; end
        if (m_bvalid) check("bresp_timeout", 1'b1, 1'b0);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        wait_b_idle();
        awvalid = 1; awaddr = addr; wvalid = 1; wdata = data; wstrb = strb;
        tick();
        awvalid = 0; wvalid = 0;
        resp = bresp;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] up;
        up = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2: return {up[31:16], 16'h4000};
            3, 4:    return {up[31:16], 16'h4004};
            5, 6:    return {up[31:16], 16'hBFF8};
            7:       return {up[31:16], 16'hBFFC};
            8:       return 32'h0000_0010;
            default: return up;
        endcase
    endfunction

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic        ar_acc, aw_acc, w_acc;

        // Reset
        reset = 1;
        repeat (3) tick();
        check("rst_mtip", mtip, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_arready", arready, 1'b1);
        check("rst_awready", awready, 1'b1);
        check("rst_wready", wready, 1'b1);
        check("rst_rdata", rdata, 32'h0);
        reset = 0;
        cyc = 0;

        // Idle 10 cycles, then read mtime low
        repeat (10) tick();
        axi_read(32'hBFF8, d, r);
        check("idle_mtime_lo", d, 32'd10);
        check("idle_mtime_resp", r, 2'b00);
        check("idle_mtip", mtip, 1'b0);

        // mtimecmp = 50: mtip must appear exactly when mtime reaches 50
        axi_write(32'h4004, 32'h0, 4'hF, r);
        check("cmp_hi_bresp", r, 2'b00);
        axi_write(32'h4000, 32'd50, 4'hF, r);
        check("cmp_lo_bresp", r, 2'b00);
        while (cyc < 55) begin
            tick();
            if (cyc == 49) check("mtip_at_49", mtip, 1'b0);
            if (cyc == 50) check("mtip_at_50", mtip, 1'b1);
        end
        check("mtip_held", mtip, 1'b1);
        mtip_clear = 1;
        tick();
        mtip_clear = 0;
        check("mtip_cleared", mtip, 1'b0);
        repeat (20) begin
            tick();
            check("mtip_no_rearm", mtip, 1'b0);
        end

        // Carry from low into high half
        axi_write(32'hBFFC, 32'h0, 4'hF, r);
        axi_write(32'hBFF8, 32'hFFFF_FFFF, 4'hF, r);
        tick();
        axi_read(32'hBFF8, d, r);
        check("carry_lo", d, 32'h0);
        axi_read(32'hBFFC, d, r);
        check("carry_hi", d, 32'h1);

        // Full 64-bit wrap
        axi_write(32'hBFFC, 32'hFFFF_FFFF, 4'hF, r);
        axi_write(32'hBFF8, 32'hFFFF_FFFF, 4'hF, r);
        tick();
        axi_read(32'hBFF8, d, r);
        check("wrap_lo", d, 32'h0);
        axi_read(32'hBFFC, d, r);
        check("wrap_hi", d, 32'h0);

        // Unmapped read, partial strobe write
        axi_read(32'h0000_0010, d, r);
        check("unmapped_rdata", d, 32'h0);
        check("unmapped_rresp", r, 2'b10);
        axi_write(32'h4000, 32'hAABB_CCDD, 4'b0010, r);
        check("strobe_bresp", r, 2'b00);
        axi_read(32'h4000, d, r);
        check("strobe_cmp_lo", d, 32'h0000_CC32);
        axi_write(32'h0000_0020, 32'h1234_5678, 4'hF, r);
        check("unmapped_bresp", r, 2'b10);

        // W three cycles ahead of AW, B stalled four cycles
        wait_b_idle();
        bready = 0;
        wvalid = 1; wdata = 32'h1; wstrb = 4'hF;
        tick();
        wvalid = 0;
        repeat (2) begin
            check("stall_wready", wready, 1'b0);
            check("stall_awready", awready, 1'b1);
            tick();
        end
        awvalid = 1; awaddr = 32'h4004;
        tick();
        awvalid = 0;
        repeat (4) begin
            check("stall_bvalid", bvalid, 1'b1);
            check("stall_aw_blocked", awready, 1'b0);
            check("stall_w_blocked", wready, 1'b0);
            tick();
        end
        bready = 1;
        tick();
        check("stall_bdone", bvalid, 1'b0);
        check("stall_awready_back", awready, 1'b1);
        axi_read(32'h4004, d, r);
        check("stall_cmp_hi", d, 32'h1);

        // Snapshot: hi read after lo returns the value captured with lo
        axi_write(32'hBFFC, 32'h0, 4'hF, r);
        axi_write(32'hBFF8, 32'hFFFF_FFF0, 4'hF, r);
        axi_read(32'hBFF8, d, r);
        check("snap_lo", d, 32'hFFFF_FFF0);
        repeat (40) tick();
        axi_read(32'hBFFC, d, r);
        check("snap_hi_shadow", d, 32'h0);
        axi_read(32'hBFFC, d, r);
        check("snap_hi_live", d, 32'h1);

        // Randomized traffic, with a reset in the middle of it
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                arvalid = 0; awvalid = 0; wvalid = 0; mtip_clear = 0;
                reset = 1;
                repeat (2) tick();
                reset = 0;
            end
            if (!arvalid && $urandom_range(0, 2) == 0) begin
                arvalid = 1; araddr = pick_addr();
            end
            if (!awvalid && !m_aw_held && $urandom_range(0, 3) == 0) begin
                awvalid = 1; awaddr = pick_addr();
            end
            if (!wvalid && !m_w_held && $urandom_range(0, 3) == 0) begin
                wvalid = 1;
                wdata  = $urandom;
                if ($urandom_range(0, 1) == 0) wdata = 32'($urandom_range(0, 2));
                wstrb  = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 0) wstrb = 4'hF;
            end
            rready     = ($urandom_range(0, 2) != 0);
            bready     = ($urandom_range(0, 2) != 0);
            mtip_clear = ($urandom_range(0, 7) == 0);
            ar_acc = arvalid && !m_rvalid;
            aw_acc = awvalid && !m_aw_held && !m_bvalid;
            w_acc  = wvalid && !m_w_held && !m_bvalid;
            tick();
            if (ar_acc) arvalid = 0;
            if (aw_acc) awvalid = 0;
            if (w_acc) wvalid = 0;
        end
        mtip_clear = 0;
        rready = 1;
        bready = 1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
